// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared definitions for the pipeline run/halt sequencer.
//                Holds the FSM state encoding, the default drain length and
//                the HALT opcode that ID decode and the hazard unit also use.
//                Optional feature macro used by this slice: CYCLE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   // Sequencer states; the encoding is visible on the state_o debug port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } run_state_t;

   // Cycles from HALT leaving ID until the last older instruction retires
   // from WB: EX, MEM, WB plus one cycle of margin.
   localparam int C_DRAIN_CYCLES_DEF = 4;

   // Opcode field value of the HALT instruction (upper nibble of the word).
   localparam logic [3:0] C_HALT_OPCODE = 4'hF;

   // Width of a down-counter that must hold values 0 .. cycles-1.
   function automatic int drain_cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_run_ctrl_if.sv
// ============================================================================
//  Module      : pipe_run_ctrl_if
//  Description : Request/strobe bundle between the run sequencer and the
//                pipeline datapath. master = sequencer side, slave = the
//                datapath/hazard side. cycle_cnt exists only when
//                CYCLE_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_run_ctrl_if
`ifdef CYCLE_COUNT_EN
   #(parameter int CNT_WIDTH = 16)
`endif
   ;

   // Requests into the sequencer
   logic       start;
   logic       halt_dec;
   logic       stall_req;
   logic       branch_taken;

   // Strobes out of the sequencer
   logic       pc_clr;
   logic       pc_en;
   logic       im_rd;
   logic       if_id_en;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       stop;
   logic [1:0] state_o;

`ifdef CYCLE_COUNT_EN
   logic [CNT_WIDTH-1:0] cycle_cnt;

   modport master (
      input  start, halt_dec, stall_req, branch_taken,
      output pc_clr, pc_en, im_rd, if_id_en, if_id_flush, id_ex_flush,
             stop, state_o, cycle_cnt
   );

   modport slave (
      output start, halt_dec, stall_req, branch_taken,
      input  pc_clr, pc_en, im_rd, if_id_en, if_id_flush, id_ex_flush,
             stop, state_o, cycle_cnt
   );
`else
   modport master (
      input  start, halt_dec, stall_req, branch_taken,
      output pc_clr, pc_en, im_rd, if_id_en, if_id_flush, id_ex_flush,
             stop, state_o
   );

   modport slave (
      output start, halt_dec, stall_req, branch_taken,
      input  pc_clr, pc_en, im_rd, if_id_en, if_id_flush, id_ex_flush,
             stop, state_o
   );
`endif

endinterface : pipe_run_ctrl_if

`default_nettype wire

// File: rtl/pipe_run_ctrl_drain_counter.sv
// ============================================================================
//  Module      : drain_counter
//  Description : Down-counter timing the pipeline drain after a HALT.
//                load presets LOAD_VAL, dec counts down (stopping at 0),
//                zero flags a count of 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drain_counter #(
   parameter int WIDTH    = 3,
   parameter int LOAD_VAL = 3
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic load,
   input  wire logic dec,
   output logic      zero
);

   localparam logic [WIDTH-1:0] c_load_val = WIDTH'(LOAD_VAL);

   logic [WIDTH-1:0] r_cnt;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= c_load_val;
      end else if (dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign zero = (r_cnt == '0);

endmodule : drain_counter

`default_nettype wire

// File: rtl/pipe_run_ctrl.sv
// ============================================================================
//  Module      : pipe_run_ctrl
//  Description : Run/halt sequencer for the 16-bit 5-stage pipeline. Turns
//                start into fetch, merges stall/branch-flush requests into
//                per-stage enables and flushes, and drains the pipe on HALT
//                before raising stop.
//                Optional feature: define CYCLE_COUNT_EN to add a saturating
//                RUN+DRAIN cycle counter on cycle_cnt (width CNT_WIDTH).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_run_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = C_DRAIN_CYCLES_DEF   // must be >= 1
`ifdef CYCLE_COUNT_EN
   , parameter int CNT_WIDTH  = 16
`endif
) (
   input  wire logic        clk,
   input  wire logic        rst,
   pipe_run_ctrl_if.master  bus
);

   localparam int c_drain_w = drain_cnt_width(DRAIN_CYCLES);

   run_state_t r_state;
   run_state_t w_state_nxt;

   logic w_pc_clr;
   logic w_pc_en;
   logic w_im_rd;
   logic w_if_id_en;
   logic w_if_id_flush;
   logic w_id_ex_flush;
   logic w_stop;
   logic w_drain_load;
   logic w_drain_dec;
   logic w_drain_zero;
   logic w_start_acc;

   // State register; reset aborts any run or drain immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe decode from current state and requests.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_clr      = 1'b0;
      w_pc_en       = 1'b0;
      w_im_rd       = 1'b0;
      w_if_id_en    = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      w_stop        = 1'b0;
      w_drain_load  = 1'b0;
      w_drain_dec   = 1'b0;
      w_start_acc   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_start_acc = 1'b1;
               w_pc_clr    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end

         ST_RUN: begin
            w_im_rd = 1'b1;
            if (bus.branch_taken) begin
               // Redirect fetch and squash both younger instructions,
               // including any HALT sitting in ID.
               w_pc_en       = 1'b1;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (bus.stall_req) begin
               // Freeze IF/ID and insert a bubble; a HALT in ID is
               // re-presented once the stall clears.
               w_id_ex_flush = 1'b1;
            end else if (bus.halt_dec) begin
               // Stop fetching and let the HALT walk down the pipe.
               w_im_rd       = 1'b0;
               w_if_id_flush = 1'b1;
               w_drain_load  = 1'b1;
               w_state_nxt   = ST_DRAIN;
            end else begin
               w_pc_en    = 1'b1;
               w_if_id_en = 1'b1;
            end
         end

         ST_DRAIN: begin
            w_id_ex_flush = 1'b1;
            w_drain_dec   = 1'b1;
            if (w_drain_zero) begin
               w_state_nxt = ST_HALT;
            end
         end

         ST_HALT: begin
            w_stop = 1'b1;
            if (bus.start) begin
               w_start_acc = 1'b1;
               w_pc_clr    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Counter is preset to DRAIN_CYCLES-1 so DRAIN lasts DRAIN_CYCLES cycles.
   drain_counter #(
      .WIDTH    (c_drain_w),
      .LOAD_VAL (DRAIN_CYCLES - 1)
   ) u_drain_counter (
      .clk  (clk),
      .rst  (rst),
      .load (w_drain_load),
      .dec  (w_drain_dec),
      .zero (w_drain_zero)
   );

   // pc_clr is the only strobe fed straight from an input while IDLE, so it
   // is masked to keep every output low throughout reset.
   assign bus.pc_clr      = w_pc_clr & ~rst;
   assign bus.pc_en       = w_pc_en;
   assign bus.im_rd       = w_im_rd;
   assign bus.if_id_en    = w_if_id_en;
   assign bus.if_id_flush = w_if_id_flush;
   assign bus.id_ex_flush = w_id_ex_flush;
   assign bus.stop        = w_stop;
   assign bus.state_o     = r_state;

`ifdef CYCLE_COUNT_EN
   logic [CNT_WIDTH-1:0] r_cycle_cnt;

   // Cleared on start acceptance, counts RUN/DRAIN cycles, saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle_cnt <= '0;
      end else if (w_start_acc) begin
         r_cycle_cnt <= '0;
      end else if ((r_state == ST_RUN || r_state == ST_DRAIN) &&
                   (r_cycle_cnt != '1)) begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   assign bus.cycle_cnt = r_cycle_cnt;
`endif

endmodule : pipe_run_ctrl

`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_run_ctrl
//  Description : Self-checking bench for pipe_run_ctrl: directed scenarios
//                with literal expectations plus randomized requests checked
//                every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_run_ctrl;

   localparam int D  = 4;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

`ifdef CYCLE_COUNT_EN
   pipe_run_ctrl_if #(.CNT_WIDTH(CW)) bus ();
   pipe_run_ctrl #(.DRAIN_CYCLES(D), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`else
   pipe_run_ctrl_if bus ();
   pipe_run_ctrl #(.DRAIN_CYCLES(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_mode: 0 idle, 1 running, 2 draining, 3 halted (matches state_o values)
   int m_mode = 0;
   int m_left = 0;   // drain cycles still to spend
   int m_cyc  = 0;   // RUN+DRAIN cycles since last start

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0;
         m_left <= 0;
         m_cyc  <= 0;
      end else begin
         case (m_mode)
            0, 3: if (bus.start) begin
               m_mode <= 1;
               m_cyc  <= 0;
            end
            1: begin
               m_cyc <= (m_cyc == (1 << CW) - 1) ? m_cyc : m_cyc + 1;
               if (bus.halt_dec && !bus.stall_req && !bus.branch_taken) begin
                  m_mode <= 2;
                  m_left <= D;
               end
            end
            default: begin
               m_cyc  <= (m_cyc == (1 << CW) - 1) ? m_cyc : m_cyc + 1;
               m_left <= m_left - 1;
               if (m_left == 1) m_mode <= 3;
            end
         endcase
      end
   end

   // Expected output vector {pc_clr,pc_en,im_rd,if_id_en,if_id_flush,id_ex_flush,stop,state[1:0]}
   function automatic logic [8:0] model_out();
      logic clr, pen, ird, ien, ifl, efl, stp;
      bit   br, st, hl, go;
      clr = 0; pen = 0; ird = 0; ien = 0; ifl = 0; efl = 0; stp = 0;
      br = bus.branch_taken; st = bus.stall_req; hl = bus.halt_dec;
      go = bus.start && !rst;
      if (m_mode == 0) begin
         clr = go;
      end else if (m_mode == 1) begin
         // fetch continues unless a HALT is actually accepted this cycle
         ird = !(hl && !br && !st);
         pen = br || (!st && !hl);
         ien = !br && !st && !hl;
         ifl = br || (!st && hl);
         efl = br || st;
      end else if (m_mode == 2) begin
         efl = 1;
      end else begin
         stp = 1;
         clr = go;
      end
      return {clr, pen, ird, ien, ifl, efl, stp, 2'(m_mode)};
   endfunction

   // Compare process: every cycle, away from the rising edge.
   always @(negedge clk) begin
      chk("outputs",
          int'({bus.pc_clr, bus.pc_en, bus.im_rd, bus.if_id_en, bus.if_id_flush,
                bus.id_ex_flush, bus.stop, bus.state_o}),
          int'(model_out()));
`ifdef CYCLE_COUNT_EN
      chk("cycle_cnt", int'(bus.cycle_cnt), m_cyc);
`endif
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit s, input bit h, input bit st, input bit b);
      @(posedge clk);
      #1;
      bus.start        = s;
      bus.halt_dec     = h;
      bus.stall_req    = st;
      bus.branch_taken = b;
      #1;
   endtask

   initial begin
      bus.start = 0; bus.halt_dec = 0; bus.stall_req = 0; bus.branch_taken = 0;

      // 1: reset, then idle with no start
      repeat (3) @(posedge clk);
      #1 rst = 0;
      repeat (10) step(0, 0, 0, 0);
      chk("idle_state", int'(bus.state_o), 0);
      chk("idle_stop", int'(bus.stop), 0);
      chk("idle_imrd", int'(bus.im_rd), 0);

      // 2: start pulse
      step(1, 0, 0, 0);
      chk("start_pc_clr", int'(bus.pc_clr), 1);
      step(0, 0, 0, 0);
      chk("run_state", int'(bus.state_o), 1);
      chk("run_imrd_pcen_ifen", int'({bus.im_rd, bus.pc_en, bus.if_id_en}), 7);
      repeat (3) step(0, 0, 0, 0);

      // 3: HALT and drain
      step(0, 1, 0, 0);
      chk("halt_ifflush_pcen", int'({bus.if_id_flush, bus.pc_en}), 2);
      for (int i = 0; i < D; i++) begin
         step(0, 0, 0, 0);
         chk("drain_state", int'(bus.state_o), 2);
      end
      step(0, 0, 0, 0);
      chk("halt_stop_state", int'({bus.stop, bus.state_o}), 7);
      step(0, 0, 1, 1);
      chk("halt_held", int'({bus.stop, bus.state_o}), 7);

      // 5: restart from HALT
      step(1, 0, 0, 0);
      chk("restart_pc_clr", int'(bus.pc_clr), 1);
      step(0, 0, 0, 0);
      chk("restart_stop_state", int'({bus.stop, bus.state_o}), 1);

      // 4: HALT masked by stall, then by branch
      step(0, 1, 1, 0);
      chk("stall_halt", int'({bus.id_ex_flush, bus.pc_en}), 2);
      step(0, 0, 0, 0);
      chk("stall_stays_run", int'(bus.state_o), 1);
      step(0, 1, 0, 1);
      chk("branch_halt", int'({bus.if_id_flush, bus.id_ex_flush}), 3);
      step(0, 0, 0, 0);
      chk("branch_stays_run", int'(bus.state_o), 1);

      // 6: asynchronous reset in the middle of a drain
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      #2 rst = 1;
      #1;
      chk("rst_drain_state", int'(bus.state_o), 0);
      chk("rst_drain_outs", int'({bus.id_ex_flush, bus.stop, bus.im_rd}), 0);
      step(0, 0, 0, 0);
      rst = 0;

      // long run to reach counter saturation
      step(1, 0, 0, 0);
      repeat (80) step(0, 0, ($urandom % 4) == 0, 0);
      step(0, 1, 0, 0);
      repeat (D + 3) step(0, 0, 0, 0);

      // randomized requests
      for (int n = 0; n < 2000; n++) begin
         step(($urandom % 6) == 0, ($urandom % 8) == 0,
              ($urandom % 5) == 0, ($urandom % 7) == 0);
         if (($urandom % 400) == 0) begin
            #2 rst = 1;
            step(0, 0, 0, 0);
            rst = 0;
         end
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_run_ctrl

`default_nettype wire
